// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder for the MEM-stage data bus: switches, keys, LEDs, 7-seg digits, timer.
// Latency: reads are combinational from register state; stores land at the rising clock edge.
// Backpressure: none; every access completes in the cycle it is presented.
module io_port_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic        io_sel,
  output logic [31:0] dataout,
  input  logic [9:0]  sw,
  input  logic [3:1]  key,
  output logic [9:0]  led,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0
);

  // Word offsets inside the 0x80..0xFC window (addr[6:2]).
  localparam logic [4:0] OFF_SW    = 5'd0;
  localparam logic [4:0] OFF_KEY   = 5'd1;
  localparam logic [4:0] OFF_LED   = 5'd2;
  localparam logic [4:0] OFF_HEX   = 5'd3;
  localparam logic [4:0] OFF_HEXEN = 5'd4;
  localparam logic [4:0] OFF_TIMER = 5'd5;

  localparam logic [15:0] LP_DB = 16'(DEBOUNCE_CYCLES);

  // Active-low segment patterns, bit6=g .. bit0=a.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Address decode and write strobes.
  logic       w_io_sel;
  logic [4:0] w_off;
  logic       w_wr;
  logic       w_wr_key;
  logic       w_wr_led;
  logic       w_wr_hex;
  logic       w_wr_hexen;
  logic       w_wr_timer;
  logic       w_unused_addr;

  assign w_io_sel      = addr[7] && (addr[31:8] == 24'd0);
  assign w_off         = addr[6:2];
  assign w_wr          = we && w_io_sel;
  assign w_wr_key      = w_wr && (w_off == OFF_KEY);
  assign w_wr_led      = w_wr && (w_off == OFF_LED);
  assign w_wr_hex      = w_wr && (w_off == OFF_HEX);
  assign w_wr_hexen    = w_wr && (w_off == OFF_HEXEN);
  assign w_wr_timer    = w_wr && (w_off == OFF_TIMER);
  // Byte lane bits do not select anything; accesses are word-wide.
  assign w_unused_addr = ^addr[1:0];
  assign io_sel        = w_io_sel;

  // Register state.
  logic [9:0]  r_sw_s1;
  logic [9:0]  r_sw_s2;
  logic [2:0]  r_key_s1;
  logic [2:0]  r_key_s2;
  logic [2:0]  r_key_lvl;
  logic [2:0]  r_key_flag;
  logic [15:0] r_db_cnt [3];
  logic [9:0]  r_led;
  logic [23:0] r_hex;
  logic [5:0]  r_hexen;
  logic [6:0]  r_seg [6];
  logic [31:0] r_timer;

  // Next-state wires.
  logic [2:0]  w_raw;
  logic [2:0]  w_lvl_nxt;
  logic [2:0]  w_rise;
  logic [2:0]  w_flag_clr;
  logic [15:0] w_cnt_nxt [3];
  logic [23:0] w_hex_nxt;
  logic [5:0]  w_hexen_nxt;
  logic [6:0]  w_seg_nxt [6];

  // Keys are active-low on the board; internally 1 means pressed.
  assign w_raw = ~r_key_s2;

  // Two-flop synchronizers; keys idle high (released) out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_key_s1 <= 3'b111;
      r_key_s2 <= 3'b111;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
    end
  end

  // Per-key debounce: count while raw differs from the accepted level, accept on reaching the limit.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_cnt_nxt[i] = '0;
      w_lvl_nxt[i] = r_key_lvl[i];
      w_rise[i]    = 1'b0;
      if (w_raw[i] != r_key_lvl[i]) begin
        if ((r_db_cnt[i] + 16'd1) == LP_DB) begin
          w_lvl_nxt[i] = w_raw[i];
          w_rise[i]    = w_raw[i];
        end else begin
          w_cnt_nxt[i] = r_db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // A W1C store cannot cancel a press detected in the same cycle: set is OR'ed in after the clear.
  assign w_flag_clr = w_wr_key ? datain[6:4] : 3'b000;

  // Debounce counters, accepted levels and sticky press flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_key_lvl  <= '0;
      r_key_flag <= '0;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_key_lvl  <= w_lvl_nxt;
      r_key_flag <= (r_key_flag & ~w_flag_clr) | w_rise;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Segment outputs are registered from the post-store HEX/HEXEN so digits move at the store edge.
  assign w_hex_nxt   = w_wr_hex   ? datain[23:0] : r_hex;
  assign w_hexen_nxt = w_wr_hexen ? datain[5:0]  : r_hexen;

  // Decode each digit nibble, blanking disabled digits.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      w_seg_nxt[k] = 7'h7F;
      if (w_hexen_nxt[k]) begin
        w_seg_nxt[k] = seg7(w_hex_nxt[4*k +: 4]);
      end
    end
  end

  // LED, HEX, HEXEN store registers and the registered segment drive.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_led   <= '0;
      r_hex   <= '0;
      r_hexen <= 6'h3F;
      for (int k = 0; k < 6; k++) begin
        r_seg[k] <= 7'h40;
      end
    end else begin
      if (w_wr_led) begin
        r_led <= datain[9:0];
      end
      r_hex   <= w_hex_nxt;
      r_hexen <= w_hexen_nxt;
      for (int k = 0; k < 6; k++) begin
        r_seg[k] <= w_seg_nxt[k];
      end
    end
  end

  // Free-running timer; a store replaces the increment in that cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_timer <= '0;
    end else if (w_wr_timer) begin
      r_timer <= datain;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  // Combinational read mux; anything outside the window or unmapped reads zero.
  always_comb begin
    dataout = 32'd0;
    if (w_io_sel) begin
      case (w_off)
        OFF_SW:    dataout = {22'd0, r_sw_s2};
        OFF_KEY:   dataout = {25'd0, r_key_flag, 1'b0, r_key_lvl};
        OFF_LED:   dataout = {22'd0, r_led};
        OFF_HEX:   dataout = {8'd0, r_hex};
        OFF_HEXEN: dataout = {26'd0, r_hexen};
        OFF_TIMER: dataout = r_timer;
        default:   dataout = 32'd0;
      endcase
    end
  end

  assign led  = r_led;
  assign hex0 = r_seg[0];
  assign hex1 = r_seg[1];
  assign hex2 = r_seg[2];
  assign hex3 = r_seg[3];
  assign hex4 = r_seg[4];
  assign hex5 = r_seg[5];

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: register map, sync/debounce latency, timer wrap, decode.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// No backpressure on this bus; every access completes in one cycle.
module tb_io_port_responder;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] datain = '0;
  logic        we = 1'b0;
  logic        io_sel;
  logic [31:0] dataout;
  logic [9:0]  sw = '0;
  logic [3:1]  key = 3'b111;
  logic [9:0]  led;
  logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;

  int n_checks = 0;
  int n_errors = 0;

  io_port_responder #(.DEBOUNCE_CYCLES(16)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .addr    (addr),
    .datain  (datain),
    .we      (we),
    .io_sel  (io_sel),
    .dataout (dataout),
    .sw      (sw),
    .key     (key),
    .led     (led),
    .hex5    (hex5),
    .hex4    (hex4),
    .hex3    (hex3),
    .hex2    (hex2),
    .hex1    (hex1),
    .hex0    (hex0)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a read address and let the combinational path settle.
  task automatic rd(input logic [31:0] a);
    addr = a;
    we   = 1'b0;
    #1;
  endtask

  // Hold a store across one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    tick();
    we     = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_val("rst_led",  {22'd0, led},  32'd0);
    check_val("rst_hex0", {25'd0, hex0}, 32'h40);
    check_val("rst_hex3", {25'd0, hex3}, 32'h40);
    check_val("rst_hex5", {25'd0, hex5}, 32'h40);
    rd(32'h90); check_val("rst_hexen", dataout, 32'h3F);
    rd(32'h84); check_val("rst_key",   dataout, 32'h0);

    // Timer runs from 0 after release
    resetn = 1'b1;
    rd(32'h94); check_val("tmr_0", dataout, 32'd0);
    tick(); rd(32'h94); check_val("tmr_1", dataout, 32'd1);
    tick(); rd(32'h94); check_val("tmr_2", dataout, 32'd2);
    check_val("io_sel_94", {31'd0, io_sel}, 32'd1);

    // LED store visible at the write edge
    addr = 32'h88; datain = 32'h3FF; we = 1'b1; #1;
    check_val("led_pre", {22'd0, led}, 32'd0);
    @(posedge clock); #1; we = 1'b0;
    check_val("led_post", {22'd0, led}, 32'h3FF);
    rd(32'h88); check_val("led_rd", dataout, 32'h3FF);

    // HEX digits
    wr(32'h8C, 32'h00ABCDEF);
    check_val("hex5_A", {25'd0, hex5}, 32'h08);
    check_val("hex4_B", {25'd0, hex4}, 32'h03);
    check_val("hex3_C", {25'd0, hex3}, 32'h46);
    check_val("hex2_D", {25'd0, hex2}, 32'h21);
    check_val("hex1_E", {25'd0, hex1}, 32'h06);
    check_val("hex0_F", {25'd0, hex0}, 32'h0E);
    rd(32'h8C); check_val("hex_rd", dataout, 32'h00ABCDEF);

    // Digit enables: only 0 and 2 lit
    wr(32'h90, 32'h05);
    check_val("en_hex0", {25'd0, hex0}, 32'h0E);
    check_val("en_hex1", {25'd0, hex1}, 32'h7F);
    check_val("en_hex2", {25'd0, hex2}, 32'h21);
    check_val("en_hex3", {25'd0, hex3}, 32'h7F);
    check_val("en_hex4", {25'd0, hex4}, 32'h7F);
    check_val("en_hex5", {25'd0, hex5}, 32'h7F);
    rd(32'h90); check_val("en_rd", dataout, 32'h05);

    // Switch synchronizer latency
    sw = 10'h2A5;
    rd(32'h80); check_val("sw_e0", dataout, 32'h0);
    tick(); rd(32'h80); check_val("sw_e1", dataout, 32'h0);
    tick(); rd(32'h80); check_val("sw_e2", dataout, 32'h2A5);

    // Short bounce on key[2] is ignored
    key = 3'b101;
    repeat (10) tick();
    key = 3'b111;
    repeat (25) tick();
    rd(32'h84); check_val("key_bounce", dataout, 32'h0);

    // Stable press on key[2]: accepted at edge 2+16
    key = 3'b101;
    repeat (17) tick();
    rd(32'h84); check_val("key_e17", dataout, 32'h0);
    tick();
    rd(32'h84); check_val("key_e18", dataout, 32'h22);
    repeat (2) tick();
    key = 3'b111;
    repeat (20) tick();
    rd(32'h84); check_val("key_rel", dataout, 32'h20);
    wr(32'h84, 32'h20);
    rd(32'h84); check_val("key_w1c", dataout, 32'h0);

    // Press on key[1] with a W1C in the very cycle the flag sets: set wins
    key = 3'b110;
    repeat (17) tick();
    wr(32'h84, 32'h10);
    rd(32'h84); check_val("key_set_vs_clr", dataout, 32'h11);
    key = 3'b111;
    repeat (20) tick();
    wr(32'h84, 32'h10);
    rd(32'h84); check_val("key_clr2", dataout, 32'h0);

    // Timer load and wrap
    wr(32'h94, 32'hFFFFFFFE);
    rd(32'h94); check_val("tmr_fe", dataout, 32'hFFFFFFFE);
    tick(); rd(32'h94); check_val("tmr_ff", dataout, 32'hFFFFFFFF);
    tick(); rd(32'h94); check_val("tmr_wrap", dataout, 32'h0);
    wr(32'h94, 32'hFFFFFFFF);
    wr(32'h94, 32'h12345678);
    rd(32'h94); check_val("tmr_wr_wins", dataout, 32'h12345678);

    // Outside the window and unmapped offsets
    addr = 32'h40; datain = 32'h0; we = 1'b1; #1;
    check_val("sel_40", {31'd0, io_sel}, 32'd0);
    check_val("dout_40", dataout, 32'h0);
    tick(); we = 1'b0;
    check_val("led_40", {22'd0, led}, 32'h3FF);
    addr = 32'hFC; datain = 32'h0; we = 1'b1; #1;
    check_val("sel_fc", {31'd0, io_sel}, 32'd1);
    check_val("dout_fc", dataout, 32'h0);
    tick(); we = 1'b0;
    check_val("led_fc", {22'd0, led}, 32'h3FF);
    check_val("hex0_fc", {25'd0, hex0}, 32'h0E);
    rd(32'h188); check_val("dout_188", dataout, 32'h0);

    // Asynchronous reset mid-count
    rd(32'h94);
    #2;
    resetn = 1'b0;
    #1;
    check_val("arst_tmr", dataout, 32'h0);
    check_val("arst_led", {22'd0, led}, 32'h0);
    check_val("arst_hex1", {25'd0, hex1}, 32'h40);
    #1;
    resetn = 1'b1;
    tick();
    rd(32'h94); check_val("arst_tmr_run", dataout, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
